multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Sequencing FSM for the multi-cycle RV32I core variant (LW, SW, R-type ADD/SUB): one instruction over several cycles.
//  Drives PC/IR/regfile/memory enables and the shared-ALU/memory mux selects each cycle; waits on memory via mem_ready.
//  Sits beside the datapath; op/func3/func7 come from the datapath's latched instruction register.
// PARAMETERS
//  WAIT_TIMEOUT  255  max cycles any state waits for mem_ready before trapping; 0 = wait forever
//  CNT_W         32   width of perf counters (CONFIGURATION only)
// PORTS
//  clk                input   1  core clock, all state on rising edge
//  rst                input   1  synchronous, active-high reset
//  op                 input   7  opcode from IR (valid from DECODE onward)
//  func3              input   3  func3 from IR
//  func7              input   7  func7 from IR
//  mem_ready          input   1  memory completed current access this cycle
//  pc_write           output  1  PC <= result
//  ir_write           output  1  IR/oldPC <= fetched word
//  adr_source         output  1  mem address: 0=PC, 1=ALU-out reg
//  mem_write          output  1  store request, held until mem_ready
//  reg_write          output  1  regfile write enable
//  alu_src_a          output  2  00=PC 01=oldPC 10=rs1 reg A
//  alu_src_b          output  2  00=rs2 reg B 01=imm 10=const 4
//  imm_source         output  2  00=I 01=S
//  result_src         output  2  00=ALU-out reg 01=mem data reg 10=ALU result
//  alu_control        output  3  000 ADD 001 SUB 111 invalid
//  instr_retired      output  1  1-cycle pulse at final state of each instruction
//  trap               output  1  sticky: illegal opcode or memory timeout; cleared by rst only
// BEHAVIOUR
//  Reset: state=FETCH, wait counter=0, trap=0; while rst=1 all enables/pulses 0, selects 00, alu_control 000.
//  Enables/selects default 0/00 in every state unless listed. States and transitions:
//   FETCH    adr_source=0, a=00,b=10,ADD,result_src=10; ir_write=pc_write=mem_ready; mem_ready -> DECODE else stay
//   DECODE   a=01,b=01 (branch target slot, unused); op 0000011/0100011 -> MEMADR, 0110011 -> EXECR, else -> TRAP
//   MEMADR   a=10,b=01,ADD; imm_source=00 (LW) / 01 (SW); -> MEMREAD (LW) or MEMWRITE (SW)
//   MEMREAD  adr_source=1; mem_ready -> MEMWB else stay
//   MEMWB    result_src=01, reg_write=1, instr_retired=1 -> FETCH
//   MEMWRITE adr_source=1, mem_write=1 every cycle until mem_ready; mem_ready -> FETCH with instr_retired=1
//   EXECR    a=10,b=00; alu_control: func3=000 & func7[5]=0 -> 000, func3=000 & func7[5]=1 -> 001, else 111 -> ALUWB
//   ALUWB    result_src=00, reg_write=1, instr_retired=1 -> FETCH (func3!=000 still retires; result undefined)
//   TRAP     all enables 0, trap=1; stay until rst
//  Latency with mem_ready=1 always: R-type 4 cycles, SW 4, LW 5.
//  Wait counter: increments in FETCH/MEMREAD/MEMWRITE while mem_ready=0, clears on mem_ready or state change;
//   WAIT_TIMEOUT!=0 and counter==WAIT_TIMEOUT-1 with mem_ready=0 -> TRAP next cycle (no write issued).
//  mem_ready in non-waiting states is ignored. Reset mid-store drops mem_write the same cycle rst is sampled.
//  All outputs are Moore (state-decoded) except ir_write/pc_write/instr_retired in FETCH/MEMWRITE (gated by mem_ready).
// CONFIGURATION
//  MULTICYCLE_CTRL_PERF_EN defined: adds outputs cycle_count[CNT_W] (increments every non-reset cycle) and
//   instret_count[CNT_W] (increments on instr_retired); both reset 0, wrap modulo 2^CNT_W, frozen in TRAP.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package rv_ctrl_pkg: opcode constants, state enum, alu_control/result_src/alu_src_a/alu_src_b encodings.
//  Sub-module alu_decoder (combinational: alu_op, func3, func7 -> alu_control), instantiated once.
// TESTING
//  R-type ADD (op=0110011,func3=0,func7=0), mem_ready=1 -> states F,D,E,W; reg_write at cycle 4, alu_control 000 in EXECR.
//  SUB func7=0100000 -> alu_control=001 in EXECR; func3=111 -> 111 and still retires.
//  LW with mem_ready low 3 cycles in MEMREAD -> stays 3 cycles, MEMWB one cycle later, total 8 cycles.
//  SW with mem_ready low 2 cycles -> mem_write high 3 consecutive cycles, adr_source=1, no reg_write, retire pulse once.
//  op=1111111 in DECODE -> TRAP next cycle, trap=1 held for 20 cycles, rst -> FETCH, trap=0.
//  WAIT_TIMEOUT=4, mem_ready stuck 0 in FETCH -> TRAP after 4 wait cycles; with PERF_EN, instret_count unchanged.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: opcodes, states, mux selects.
package rv_ctrl_pkg;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRtype = 7'b0110011;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StAluWb,
    StTrap
  } state_e;

  typedef enum logic [1:0] {
    AluOpAdd,
    AluOpSub,
    AluOpFunc
  } alu_op_e;

  localparam logic [2:0] AluCtlAdd     = 3'b000;
  localparam logic [2:0] AluCtlSub     = 3'b001;
  localparam logic [2:0] AluCtlInvalid = 3'b111;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResMemData   = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  // States that stall on memory and are subject to the wait timeout.
  function automatic logic is_wait_state(state_e s);
    return (s == StFetch) || (s == StMemRead) || (s == StMemWrite);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from the FSM's ALU op request and the instruction fields.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  alu_op_e     alu_op,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  output logic [2:0]  alu_control
);

  // Only func7[5] distinguishes ADD from SUB in this subset.
  logic w_unused_func7;
  assign w_unused_func7 = ^{func7[6], func7[4:0]};

  always_comb begin
    alu_control = AluCtlAdd;
    unique case (alu_op)
      AluOpAdd: alu_control = AluCtlAdd;
      AluOpSub: alu_control = AluCtlSub;
      AluOpFunc: begin
        if (func3 == 3'b000) begin
          alu_control = func7[5] ? AluCtlSub : AluCtlAdd;
        end else begin
          alu_control = AluCtlInvalid;
        end
      end
      default: alu_control = AluCtlAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Sequencing FSM for the multi-cycle RV32I core (LW, SW, ADD/SUB), with memory wait timeout.
// Define MULTICYCLE_CTRL_PERF_EN to add the cycle_count/instret_count performance counters.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 255
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  op,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        adr_source,
  output logic        mem_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  imm_source,
  output logic [1:0]  result_src,
  output logic [2:0]  alu_control,
  output logic        instr_retired,
  output logic        trap
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
`endif
);

  localparam int unsigned WaitW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

  state_e           r_state, w_state_next;
  logic [WaitW-1:0] r_wait_cnt, w_wait_next;
  logic             w_timeout;
  alu_op_e          w_alu_op;
  logic [2:0]       w_alu_ctl;

  alu_decoder u_alu_decoder (
    .alu_op      (w_alu_op),
    .func3       (func3),
    .func7       (func7),
    .alu_control (w_alu_ctl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StFetch;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
    end
  end

  assign w_timeout = (WAIT_TIMEOUT != 0) && is_wait_state(r_state) && !mem_ready &&
                     (r_wait_cnt == WaitW'(WAIT_TIMEOUT - 1));

  always_comb begin
    w_state_next  = r_state;
    w_alu_op      = AluOpAdd;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    adr_source    = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SrcAPc;
    alu_src_b     = SrcBRs2;
    imm_source    = ImmI;
    result_src    = ResAluOut;
    instr_retired = 1'b0;
    trap          = 1'b0;

    unique case (r_state)
      StFetch: begin
        alu_src_b  = SrcBFour;
        result_src = ResAluResult;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (w_timeout)      w_state_next = StTrap;
        else if (mem_ready) w_state_next = StDecode;
      end
      StDecode: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
        if (op == OpLoad || op == OpStore) w_state_next = StMemAdr;
        else if (op == OpRtype)            w_state_next = StExecR;
        else                               w_state_next = StTrap;
      end
      StMemAdr: begin
        alu_src_a    = SrcARs1;
        alu_src_b    = SrcBImm;
        imm_source   = (op == OpStore) ? ImmS : ImmI;
        w_state_next = (op == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        adr_source = 1'b1;
        if (w_timeout)      w_state_next = StTrap;
        else if (mem_ready) w_state_next = StMemWb;
      end
      StMemWb: begin
        result_src    = ResMemData;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        w_state_next  = StFetch;
      end
      StMemWrite: begin
        adr_source    = 1'b1;
        mem_write     = 1'b1;
        instr_retired = mem_ready;
        if (w_timeout)      w_state_next = StTrap;
        else if (mem_ready) w_state_next = StFetch;
      end
      StExecR: begin
        alu_src_a    = SrcARs1;
        alu_src_b    = SrcBRs2;
        w_alu_op     = AluOpFunc;
        w_state_next = StAluWb;
      end
      StAluWb: begin
        result_src    = ResAluOut;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        w_state_next  = StFetch;
      end
      StTrap: begin
        trap = 1'b1;
      end
      default: w_state_next = StTrap;
    endcase

    alu_control = w_alu_ctl;

    // Reset is synchronous, so mask the stale state's outputs during the reset cycle itself.
    if (rst) begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      adr_source    = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = SrcAPc;
      alu_src_b     = SrcBRs2;
      imm_source    = ImmI;
      result_src    = ResAluOut;
      alu_control   = AluCtlAdd;
      instr_retired = 1'b0;
      trap          = 1'b0;
    end
  end

  always_comb begin
    w_wait_next = '0;
    if (is_wait_state(r_state) && !mem_ready && (w_state_next == r_state)) begin
      w_wait_next = r_wait_cnt + WaitW'(1);
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_cycle_cnt, r_instret_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else if (r_state != StTrap) begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (instr_retired) r_instret_cnt <= r_instret_cnt + CNT_W'(1);
    end
  end

  assign cycle_count   = r_cycle_cnt;
  assign instret_count = r_instret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control vectors via a scoreboard queue.
module tb_multicycle_control;

  localparam int SRst  = 0;
  localparam int SF    = 1;
  localparam int SD    = 2;
  localparam int SMA   = 3;
  localparam int SMR   = 4;
  localparam int SMWB  = 5;
  localparam int SMW   = 6;
  localparam int SE    = 7;
  localparam int SAW   = 8;
  localparam int ST    = 9;

  localparam logic [6:0] OpLw = 7'b0000011;
  localparam logic [6:0] OpSw = 7'b0100011;
  localparam logic [6:0] OpR  = 7'b0110011;

  typedef logic [17:0] vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       mem_ready;
  logic       pc_write, ir_write, adr_source, mem_write, reg_write, instr_retired, trap;
  logic [1:0] alu_src_a, alu_src_b, imm_source, result_src;
  logic [2:0] alu_control;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_count, instret_count;
  int unsigned m_cycles = 0;
  int unsigned m_instret = 0;
`endif

  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multicycle_control #(
    .WAIT_TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .op            (op),
    .func3         (func3),
    .func7         (func7),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .ir_write      (ir_write),
    .adr_source    (adr_source),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .imm_source    (imm_source),
    .result_src    (result_src),
    .alu_control   (alu_control),
    .instr_retired (instr_retired),
    .trap          (trap)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cycle_count   (cycle_count),
    .instret_count (instret_count)
`endif
  );

  // Expected outputs for one cycle in a given state, straight from the state table.
  function automatic vec_t expv(input int s, input logic rdy, input logic [2:0] alu,
                                input logic [1:0] imm);
    logic       pcw, irw, adr, mw, rw, ret, tr;
    logic [1:0] a, b, im, res;
    logic [2:0] ac;
    {pcw, irw, adr, mw, rw, ret, tr} = '0;
    {a, b, im, res} = '0;
    ac = 3'b000;
    case (s)
      SF:   begin b = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
      SD:   begin a = 2'b01; b = 2'b01; end
      SMA:  begin a = 2'b10; b = 2'b01; im = imm; end
      SMR:  adr = 1'b1;
      SMWB: begin res = 2'b01; rw = 1'b1; ret = 1'b1; end
      SMW:  begin adr = 1'b1; mw = 1'b1; ret = rdy; end
      SE:   begin a = 2'b10; b = 2'b00; ac = alu; end
      SAW:  begin res = 2'b00; rw = 1'b1; ret = 1'b1; end
      ST:   tr = 1'b1;
      default: ;
    endcase
    return {pcw, irw, adr, mw, rw, a, b, im, res, ac, ret, tr};
  endfunction

  task automatic step(input int s, input logic rdy, input logic [2:0] alu, input logic [1:0] imm,
                      input string tag);
    vec_t got, exp;
    mem_ready = rdy;
    exp_q.push_back(expv(s, rdy, alu, imm));
    @(negedge clk);
    got = {pc_write, ir_write, adr_source, mem_write, reg_write, alu_src_a, alu_src_b,
           imm_source, result_src, alu_control, instr_retired, trap};
    exp = exp_q.pop_front();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
`ifdef MULTICYCLE_CTRL_PERF_EN
    checks++;
    assert (instret_count === m_instret) else begin
      errors++;
      $error("FAIL %s instret: observed %0d expected %0d", tag, instret_count, m_instret);
    end
    checks++;
    assert (cycle_count === m_cycles) else begin
      errors++;
      $error("FAIL %s cycles: observed %0d expected %0d", tag, cycle_count, m_cycles);
    end
    if (rst) begin
      m_cycles  = 0;
      m_instret = 0;
    end else if (!exp[0]) begin
      m_cycles++;
      if (exp[1]) m_instret++;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; op = OpR; func3 = 3'b000; func7 = 7'b0;
    @(posedge clk);
    #1;
    step(SRst, 1'b0, 3'b000, 2'b00, "reset0");
    step(SRst, 1'b1, 3'b000, 2'b00, "reset1");
    rst = 1'b0;

    // R-type ADD / SUB / invalid func3
    step(SF, 1'b1, 3'b000, 2'b00, "add_fetch");
    step(SD, 1'b1, 3'b000, 2'b00, "add_decode");
    step(SE, 1'b1, 3'b000, 2'b00, "add_exec");
    step(SAW, 1'b1, 3'b000, 2'b00, "add_wb");
    func7 = 7'b0100000;
    step(SF, 1'b1, 3'b000, 2'b00, "sub_fetch");
    step(SD, 1'b1, 3'b000, 2'b00, "sub_decode");
    step(SE, 1'b1, 3'b001, 2'b00, "sub_exec");
    step(SAW, 1'b1, 3'b000, 2'b00, "sub_wb");
    func3 = 3'b111; func7 = 7'b0;
    step(SF, 1'b1, 3'b000, 2'b00, "f3_fetch");
    step(SD, 1'b1, 3'b000, 2'b00, "f3_decode");
    step(SE, 1'b1, 3'b111, 2'b00, "f3_exec");
    step(SAW, 1'b1, 3'b000, 2'b00, "f3_wb");

    // LW with three wait cycles in MEMREAD
    op = OpLw; func3 = 3'b010;
    step(SF, 1'b1, 3'b000, 2'b00, "lw_fetch");
    step(SD, 1'b1, 3'b000, 2'b00, "lw_decode");
    step(SMA, 1'b1, 3'b000, 2'b00, "lw_memadr");
    for (int i = 0; i < 3; i++) step(SMR, 1'b0, 3'b000, 2'b00, "lw_read_wait");
    step(SMR, 1'b1, 3'b000, 2'b00, "lw_read_done");
    step(SMWB, 1'b1, 3'b000, 2'b00, "lw_wb");

    // SW with two wait cycles
    op = OpSw;
    step(SF, 1'b1, 3'b000, 2'b00, "sw_fetch");
    step(SD, 1'b0, 3'b000, 2'b00, "sw_decode");
    step(SMA, 1'b1, 3'b000, 2'b01, "sw_memadr");
    step(SMW, 1'b0, 3'b000, 2'b00, "sw_write_wait0");
    step(SMW, 1'b0, 3'b000, 2'b00, "sw_write_wait1");
    step(SMW, 1'b1, 3'b000, 2'b00, "sw_write_done");

    // Reset in the middle of a store
    step(SF, 1'b1, 3'b000, 2'b00, "sw2_fetch");
    step(SD, 1'b1, 3'b000, 2'b00, "sw2_decode");
    step(SMA, 1'b1, 3'b000, 2'b01, "sw2_memadr");
    step(SMW, 1'b0, 3'b000, 2'b00, "sw2_write_wait");
    rst = 1'b1;
    step(SRst, 1'b0, 3'b000, 2'b00, "sw2_reset");
    rst = 1'b0;
    step(SF, 1'b1, 3'b000, 2'b00, "post_rst_fetch");
    step(SD, 1'b1, 3'b000, 2'b00, "post_rst_decode");
    step(SMA, 1'b1, 3'b000, 2'b01, "post_rst_memadr");
    step(SMW, 1'b1, 3'b000, 2'b00, "post_rst_write");

    // Illegal opcode traps and stays trapped until reset
    op = 7'b1111111;
    step(SF, 1'b1, 3'b000, 2'b00, "ill_fetch");
    step(SD, 1'b1, 3'b000, 2'b00, "ill_decode");
    for (int i = 0; i < 20; i++) step(ST, logic'(i % 2), 3'b000, 2'b00, "ill_trap");
    rst = 1'b1;
    step(SRst, 1'b0, 3'b000, 2'b00, "ill_reset");
    rst = 1'b0;

    // Memory timeout in FETCH after four wait cycles
    op = OpR;
    for (int i = 0; i < 4; i++) step(SF, 1'b0, 3'b000, 2'b00, "to_fetch_wait");
    for (int i = 0; i < 3; i++) step(ST, 1'b1, 3'b000, 2'b00, "to_trap");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
